// File: rtl/systemizer_loader.sv
// Packs a row-major L x K GF(M) matrix into BLOCK-element RAM words, starts the systemizer and
// latches its verdict. Optional feature macro: SYSTEMIZER_LOADER_RANGE_CHECK_EN (element range check).
module systemizer_loader #(
   parameter int L     = 8,
   parameter int K     = 16,
   parameter int M     = 3,
   parameter int BLOCK = 4,
   localparam int ELEM_W = $clog2(M),
   localparam int WORD_W = BLOCK * ELEM_W,
   localparam int DEPTH  = (L * K) / BLOCK,
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_go,
   input  logic              in_valid,
   input  logic [ELEM_W-1:0] in_elem,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              sys_start,
   input  logic              sys_done,
   input  logic              sys_success,
   input  logic              sys_fail,
   output logic              busy,
   output logic              done,
   output logic              success,
   output logic              fail,
   output logic              range_err
);

   localparam int LANE_W = (BLOCK > 1) ? $clog2(BLOCK) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT,
      S_REPORT
   } state_t;

   state_t            state, state_nxt;
   logic [LANE_W-1:0] lane;
   logic [ADDR_W-1:0] word;
   logic [WORD_W-1:0] pack, pack_nxt;
   logic              load_full;
   logic              accept;
   logic              last_lane;
   logic              last_word;
   logic              load_begin;
   logic [ELEM_W-1:0] elem_v;

   assign accept     = in_valid & in_ready;
   assign last_lane  = (lane == LANE_W'(BLOCK - 1));
   assign last_word  = (word == ADDR_W'(DEPTH - 1));
   assign load_begin = (state == S_IDLE) & load_go;

`ifdef SYSTEMIZER_LOADER_RANGE_CHECK_EN
   logic elem_bad;
   logic range_err_q;

   function automatic logic elem_out_of_range(input logic [ELEM_W-1:0] e);
      return {{(32 - ELEM_W){1'b0}}, e} >= 32'(M);
   endfunction

   assign elem_bad  = elem_out_of_range(in_elem);
   assign elem_v    = elem_bad ? '0 : in_elem;
   assign range_err = range_err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         range_err_q <= 1'b0;
      end else if (load_begin) begin
         range_err_q <= 1'b0;
      end else if (accept && elem_bad) begin
         range_err_q <= 1'b1;
      end
   end
`else
   assign elem_v    = in_elem;
   assign range_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // load_full marks the cycle carrying the final write; in_ready is already low there.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      sys_start = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (load_go) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            in_ready = ~load_full;
            if (load_full) state_nxt = S_START;
         end
         S_START: begin
            sys_start = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (sys_done) state_nxt = S_REPORT;
         end
         S_REPORT: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pack_nxt = pack;
      pack_nxt[lane * ELEM_W +: ELEM_W] = elem_v;
   end

   // Stage p0 -> p1: beat into pack register; a completed word is presented to RAM one cycle later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane      <= '0;
         word      <= '0;
         pack      <= '0;
         load_full <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         success   <= 1'b0;
         fail      <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         if (load_begin) begin
            lane      <= '0;
            word      <= '0;
            load_full <= 1'b0;
            success   <= 1'b0;
            fail      <= 1'b0;
         end
         if (accept) begin
            pack <= pack_nxt;
            if (last_lane) begin
               lane    <= '0;
               wr_en   <= 1'b1;
               wr_addr <= word;
               wr_data <= pack_nxt;
               word    <= word + 1'b1;
               if (last_word) load_full <= 1'b1;
            end else begin
               lane <= lane + 1'b1;
            end
         end
         if (state == S_WAIT && sys_done) begin
            success <= sys_success;
            fail    <= sys_fail;
         end
      end
   end

endmodule

// File: tb/tb_systemizer_loader.sv
// Directed bench for systemizer_loader: reference words are rebuilt from the element list each write.
module tb_systemizer_loader;

   localparam int L      = 8;
   localparam int K      = 16;
   localparam int M      = 3;
   localparam int BLOCK  = 4;
   localparam int ELEM_W = $clog2(M);
   localparam int WORD_W = BLOCK * ELEM_W;
   localparam int DEPTH  = (L * K) / BLOCK;
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int N      = L * K;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              load_go = 1'b0;
   logic              in_valid = 1'b0;
   logic [ELEM_W-1:0] in_elem = '0;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WORD_W-1:0] wr_data;
   logic              sys_start;
   logic              sys_done = 1'b0;
   logic              sys_success = 1'b0;
   logic              sys_fail = 1'b0;
   logic              busy;
   logic              done;
   logic              success;
   logic              fail;
   logic              range_err;

   systemizer_loader #(.L(L), .K(K), .M(M), .BLOCK(BLOCK)) dut (
      .clk(clk), .rst_n(rst_n), .load_go(load_go), .in_valid(in_valid), .in_elem(in_elem),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .sys_start(sys_start), .sys_done(sys_done), .sys_success(sys_success), .sys_fail(sys_fail),
      .busy(busy), .done(done), .success(success), .fail(fail), .range_err(range_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int elems[N];
   int wr_idx = 0;
   int start_cnt = 0;
   int done_cnt = 0;
   int last_wr_cyc = -100;
   int word0 = -1;
   int word1 = -1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference word: elements w*BLOCK .. w*BLOCK+BLOCK-1, lane j at bit offset j*ELEM_W.
   function automatic int model_word(input int w);
      int acc;
      int e;
      acc = 0;
      for (int j = 0; j < BLOCK; j++) begin
         e = elems[w * BLOCK + j];
`ifdef SYSTEMIZER_LOADER_RANGE_CHECK_EN
         if (e >= M) e = 0;
`endif
         acc = acc + (e << (j * ELEM_W));
      end
      return acc;
   endfunction

   // Advance one cycle and check the write/start stream at the falling edge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (rst_n && !busy) wr_idx = 0;
      if (rst_n && wr_en) begin
         if (wr_idx >= DEPTH) begin
            chk("write_count_limit", wr_idx + 1, DEPTH);
         end else begin
            chk("wr_addr", int'(wr_addr), wr_idx);
            chk("wr_data", int'(wr_data), model_word(wr_idx));
            if (wr_idx == 0) word0 = int'(wr_data);
            if (wr_idx == 1) word1 = int'(wr_data);
         end
         wr_idx++;
         last_wr_cyc = cyc;
      end
      if (rst_n && sys_start) begin
         start_cnt++;
         chk("start_after_last_write", cyc - last_wr_cyc, 1);
         chk("writes_before_start", wr_idx, DEPTH);
      end
      if (rst_n && done) done_cnt++;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, int'(in_ready), 0);
      chk({tag, "_wr_en"}, int'(wr_en), 0);
      chk({tag, "_wr_addr"}, int'(wr_addr), 0);
      chk({tag, "_wr_data"}, int'(wr_data), 0);
      chk({tag, "_sys_start"}, int'(sys_start), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_success"}, int'(success), 0);
      chk({tag, "_fail"}, int'(fail), 0);
      chk({tag, "_range_err"}, int'(range_err), 0);
   endtask

   task automatic fill_mod3();
      for (int i = 0; i < N; i++) elems[i] = i % 3;
   endtask

   task automatic run_load(input bit throttle, input bit spur_done);
      int i;
      int guard;
      int g;
      i = 0;
      guard = 0;
      start_cnt = 0;
      done_cnt = 0;
      load_go = 1'b1;
      tick();
      load_go = 1'b0;
      chk("load_busy", int'(busy), 1);
      chk("load_success_cleared", int'(success), 0);
      chk("load_fail_cleared", int'(fail), 0);
      chk("load_range_err_cleared", int'(range_err), 0);
      while (i < N && guard < 4 * N) begin
         guard++;
         if (throttle && (guard % 2 == 0)) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_elem  = ELEM_W'(elems[i]);
         end
         sys_done    = spur_done && (guard >= 10) && (guard < 13);
         sys_success = sys_done;
         sys_fail    = sys_done;
         if (in_valid && in_ready) i++;
         tick();
      end
      sys_done = 1'b0;
      sys_success = 1'b0;
      sys_fail = 1'b0;
      chk("beats_accepted", i, N);
      chk("in_ready_after_last_beat", int'(in_ready), 0);
      in_elem = '1;
      g = 0;
      while (start_cnt == 0 && g < 20) begin
         g++;
         tick();
      end
      in_valid = 1'b0;
      chk("sys_start_seen", start_cnt, 1);
   endtask

   task automatic verdict(input logic s, input logic f, input bit spur_go);
      tick();
      if (spur_go) load_go = 1'b1;
      tick();
      load_go = 1'b0;
      sys_done = 1'b1;
      sys_success = s;
      sys_fail = f;
      tick();
      sys_done = 1'b0;
      sys_success = 1'b0;
      sys_fail = 1'b0;
      chk("done_pulse", int'(done), 1);
      chk("success_latched", int'(success), int'(s));
      chk("fail_latched", int'(fail), int'(f));
      for (int c = 0; c < 6; c++) tick();
      chk("done_count", done_cnt, 1);
      chk("start_count", start_cnt, 1);
      chk("idle_after_report", int'(busy), 0);
      chk("success_held", int'(success), int'(s));
      chk("fail_held", int'(fail), int'(f));
   endtask

   initial begin
      int cnt;
      fill_mod3();

      // Power-on reset
      rst_n = 1'b0;
      tick();
      tick();
      chk_all_zero("por");
      rst_n = 1'b1;
      tick();

      // Reset mid-LOAD
      load_go = 1'b1;
      tick();
      load_go = 1'b0;
      for (int b = 0; b < 10; b++) begin
         in_valid = 1'b1;
         in_elem = ELEM_W'(elems[b]);
         tick();
      end
      rst_n = 1'b0;
      tick();
      chk_all_zero("rst1");
      tick();
      chk_all_zero("rst2");
      rst_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (wr_en || in_ready || busy) cnt++;
      end
      in_valid = 1'b0;
      chk("activity_after_reset", cnt, 0);

      // Full load, continuous beats, success verdict
      word0 = -1;
      run_load(1'b0, 1'b0);
      chk("word0_literal", word0, 8'b00_10_01_00);
      verdict(1'b1, 1'b0, 1'b0);

      // Throttled load, fail verdict; success from previous load must clear
      run_load(1'b1, 1'b0);
      verdict(1'b0, 1'b1, 1'b0);

      // Spurious sys_done during LOAD and load_go during WAIT
      run_load(1'b0, 1'b1);
      verdict(1'b1, 1'b0, 1'b1);

      // Out-of-range element at index 5, both verdict bits set
      elems[5] = 3;
      word1 = -1;
      run_load(1'b0, 1'b0);
`ifdef SYSTEMIZER_LOADER_RANGE_CHECK_EN
      chk("word1_literal", word1, 8'b01_00_00_01);
      chk("range_err_set", int'(range_err), 1);
`else
      chk("word1_literal", word1, 8'b01_00_11_01);
      chk("range_err_set", int'(range_err), 0);
`endif
      verdict(1'b1, 1'b1, 1'b0);
`ifdef SYSTEMIZER_LOADER_RANGE_CHECK_EN
      chk("range_err_sticky", int'(range_err), 1);
`else
      chk("range_err_sticky", int'(range_err), 0);
`endif

      // Clean load clears range_err on load_go
      fill_mod3();
      run_load(1'b1, 1'b0);
      verdict(1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
